// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg : shared opcode constants and control-path enums for the RV32I core
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_INCPC  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_JUMP   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_TRAP   = 3'd7
  } ctrl_state_e;

  typedef enum logic [1:0] {
    DB_PC   = 2'd0,
    DB_RS1  = 2'd1,
    DB_RS2  = 2'd2,
    DB_NONE = 2'd3
  } dbus_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    IC_ALU     = 3'd0,
    IC_BRANCH  = 3'd1,
    IC_JUMP    = 3'd2,
    IC_LOAD    = 3'd3,
    IC_STORE   = 3'd4,
    IC_FENCE   = 3'd5,
    IC_ILLEGAL = 3'd6
  } instr_class_e;

endpackage

`default_nettype wire

// File: rtl/rv_ctrl_decode.sv
// ----------------------------------------------------------------------------
// rv_ctrl_decode : combinational instruction classifier for the control FSM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rv_ctrl_decode
  import rv_pkg::*;
(
  input  logic [31:0]  i_ir,
  output instr_class_e o_class,
  output logic         o_legal,
  output logic         o_pc_rel,
  output logic         o_rd_nz,
  output logic [1:0]   o_mem_size
);

  logic [6:0] w_opc;
  logic       w_unused_ir;

  assign w_opc       = i_ir[6:0];
  assign w_unused_ir = ^{i_ir[31:14]};

  always_comb begin
    o_class = IC_ILLEGAL;
    unique case (w_opc)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: o_class = IC_ALU;
      OPC_BRANCH:                             o_class = IC_BRANCH;
      OPC_JAL, OPC_JALR:                      o_class = IC_JUMP;
      OPC_LOAD:                               o_class = IC_LOAD;
      OPC_STORE:                              o_class = IC_STORE;
      OPC_FENCE:                              o_class = IC_FENCE;
      default:                                o_class = IC_ILLEGAL;
    endcase
  end

  assign o_legal    = (o_class != IC_ILLEGAL);
  // AUIPC and JAL compute from the PC, everything else from rs1
  assign o_pc_rel   = (w_opc == OPC_AUIPC) || (w_opc == OPC_JAL);
  assign o_rd_nz    = (i_ir[11:7] != 5'd0);
  assign o_mem_size = i_ir[13:12];

endmodule

`default_nettype wire

// File: rtl/rv_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// rv_ctrl_fsm : multi-cycle RV32I control sequencer with memory handshake,
//               bus timeout trap and retired-instruction counter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rv_ctrl_fsm
  import rv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       mem_size,
  output logic             addr_sel,
  output logic             ir_ld,
  output logic             pc_ld,
  output logic             pc_src,
  output logic             t0_ld,
  output logic             mar_ld,
  output logic [1:0]       dbus_sel,
  output logic             aluinc,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic             trap_cause
);

  localparam logic [15:0] c_wait_last = 16'(MEM_TIMEOUT - 1);

  ctrl_state_e  r_state;
  logic [15:0]  r_wait;
  logic [CNT_W-1:0] r_instret;
  logic         r_trap;
  logic         r_trap_cause;

  instr_class_e w_class;
  logic         w_legal;
  logic         w_pc_rel;
  logic         w_rd_nz;
  logic [1:0]   w_mem_size;
  logic         w_waiting;
  logic         w_timeout;
  logic         w_retire;

  rv_ctrl_decode u_decode (
    .i_ir       (ir),
    .o_class    (w_class),
    .o_legal    (w_legal),
    .o_pc_rel   (w_pc_rel),
    .o_rd_nz    (w_rd_nz),
    .o_mem_size (w_mem_size)
  );

  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
  assign w_timeout = w_waiting && (r_wait == c_wait_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_wait       <= '0;
      r_instret    <= '0;
      r_trap       <= 1'b0;
      r_trap_cause <= 1'b0;
    end else begin
      r_wait    <= (w_waiting && !w_timeout) ? r_wait + 16'd1 : '0;
      r_instret <= r_instret + CNT_W'(w_retire);
      unique case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_state <= S_INCPC;
          end else if (w_timeout) begin
            r_state      <= S_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= 1'b1;
          end
        end
        S_INCPC: r_state <= S_DECODE;
        S_DECODE: begin
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_state      <= S_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= 1'b0;
          end
        end
        S_EXEC: begin
          unique case (w_class)
            IC_ALU, IC_BRANCH, IC_FENCE: r_state <= S_FETCH;
            IC_JUMP:                     r_state <= S_JUMP;
            IC_LOAD, IC_STORE:           r_state <= S_MEM;
            default: begin
              r_state      <= S_TRAP;
              r_trap       <= 1'b1;
              r_trap_cause <= 1'b0;
            end
          endcase
        end
        S_JUMP: r_state <= S_FETCH;
        S_MEM: begin
          if (mem_ready) begin
            r_state <= (w_class == IC_STORE) ? S_FETCH : S_WB;
          end else if (w_timeout) begin
            r_state      <= S_TRAP;
            r_trap       <= 1'b1;
            r_trap_cause <= 1'b1;
          end
        end
        S_WB:    r_state <= S_FETCH;
        default: r_state <= S_TRAP;
      endcase
    end
  end

  // Gated by reset so an abort idles the bus within the same cycle
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_size = SIZE_WORD;
    addr_sel = 1'b0;
    ir_ld    = 1'b0;
    pc_ld    = 1'b0;
    pc_src   = 1'b0;
    t0_ld    = 1'b0;
    mar_ld   = 1'b0;
    dbus_sel = DB_NONE;
    aluinc   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    w_retire = 1'b0;
    if (!reset) begin
      unique case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_ld   = mem_ready;
        end
        S_INCPC: begin
          dbus_sel = DB_PC;
          aluinc   = 1'b1;
          pc_ld    = 1'b1;
        end
        S_DECODE: begin
          dbus_sel = DB_RS2;
          t0_ld    = 1'b1;
        end
        S_EXEC: begin
          dbus_sel = w_pc_rel ? DB_PC : DB_RS1;
          unique case (w_class)
            IC_ALU: begin
              rf_we    = w_rd_nz;
              w_retire = 1'b1;
            end
            IC_BRANCH: begin
              pc_ld    = 1'b1;
              w_retire = 1'b1;
            end
            IC_FENCE: w_retire = 1'b1;
            IC_JUMP: begin
              mar_ld = 1'b1;
              rf_we  = w_rd_nz;
              wb_sel = WB_PC;
            end
            IC_LOAD, IC_STORE: mar_ld = 1'b1;
            default: ;
          endcase
        end
        S_JUMP: begin
          pc_ld    = 1'b1;
          pc_src   = 1'b1;
          w_retire = 1'b1;
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_size = w_mem_size;
          if (w_class == IC_STORE) begin
            mem_we   = 1'b1;
            dbus_sel = DB_RS1;
            w_retire = mem_ready;
          end
        end
        S_WB: begin
          rf_we    = w_rd_nz;
          wb_sel   = WB_MEM;
          w_retire = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign retire     = w_retire;
  assign instret    = r_instret;
  assign trap       = r_trap;
  assign trap_cause = r_trap_cause;

endmodule

`default_nettype wire

// File: tb/tb_rv_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_rv_ctrl_fsm : scoreboard bench; per-cycle expected outputs are queued as
//                  stimulus is driven and compared on the falling edge
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rv_ctrl_fsm;

  localparam int TMO = 4;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_size;
    logic       addr_sel;
    logic       ir_ld;
    logic       pc_ld;
    logic       pc_src;
    logic       t0_ld;
    logic       mar_ld;
    logic [1:0] dbus_sel;
    logic       aluinc;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       retire;
    logic       trap;
    logic       trap_cause;
  } out_t;

  typedef struct packed {
    logic [63:0] tag;
    out_t        o;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ir = 32'h0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_ld, pc_ld, pc_src, t0_ld, mar_ld;
  logic        aluinc, rf_we, retire, trap, trap_cause;
  logic [1:0]  mem_size, dbus_sel, wb_sel;
  logic [31:0] instret;

  out_t        act;
  exp_t        exp_q[$];
  logic [31:0] m_instret = 32'd0;
  logic [31:0] cur_ir = 32'h0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  rv_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .ir(ir), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .addr_sel(addr_sel),
    .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_src(pc_src), .t0_ld(t0_ld), .mar_ld(mar_ld),
    .dbus_sel(dbus_sel), .aluinc(aluinc), .rf_we(rf_we), .wb_sel(wb_sel),
    .retire(retire), .instret(instret), .trap(trap), .trap_cause(trap_cause)
  );

  assign act = {mem_req, mem_we, mem_size, addr_sel, ir_ld, pc_ld, pc_src, t0_ld,
                mar_ld, dbus_sel, aluinc, rf_we, wb_sel, retire, trap, trap_cause};

  task automatic check_eq(input logic [63:0] tag, input logic [63:0] got,
                          input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_eq(e.tag, 64'(act), 64'(e.o));
      check_eq("instret", 64'(instret), 64'(e.cnt));
    end
  end

  function automatic out_t idle_o();
    out_t o;
    o = '0;
    o.mem_size = 2'd2;
    o.dbus_sel = 2'd3;
    return o;
  endfunction

  // One clock of stimulus plus the outputs the DUT must show during it
  task automatic cyc(input logic rst_v, input logic rdy, input out_t o,
                     input logic [63:0] tag);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst_v;
    mem_ready = rdy;
    ir        = cur_ir;
    if (rst_v) m_instret = 32'd0;
    e.tag = tag;
    e.o   = o;
    e.cnt = m_instret;
    exp_q.push_back(e);
    if (o.retire) m_instret = m_instret + 32'd1;
  endtask

  task automatic do_reset();
    repeat (2) cyc(1'b1, 1'b0, idle_o(), "RESET");
  endtask

  task automatic trap_cycles(input logic cause);
    out_t t;
    t = idle_o();
    t.trap = 1'b1;
    t.trap_cause = cause;
    repeat (2) cyc(1'b0, 1'b1, t, "TRAP");
  endtask

  task automatic ph_fetch(input int fwait);
    out_t o;
    o = idle_o();
    o.mem_req = 1'b1;
    repeat (fwait) cyc(1'b0, 1'b0, o, "FETCHW");
    o.ir_ld = 1'b1;
    cyc(1'b0, 1'b1, o, "FETCH");
  endtask

  task automatic ph_front();
    out_t o;
    o = idle_o();
    o.dbus_sel = 2'd0;
    o.aluinc   = 1'b1;
    o.pc_ld    = 1'b1;
    cyc(1'b0, 1'b1, o, "INCPC");
    o = idle_o();
    o.dbus_sel = 2'd2;
    o.t0_ld    = 1'b1;
    cyc(1'b0, 1'b1, o, "DECODE");
  endtask

  // mwait < 0 means memory never answers (bus timeout)
  task automatic run_instr(input logic [31:0] instr, input int fwait, input int mwait);
    out_t o;
    logic [6:0] opc;
    logic rdnz, st;
    cur_ir = instr;
    opc  = instr[6:0];
    rdnz = (instr[11:7] != 5'd0);
    st   = (opc == 7'h23);
    ph_fetch(fwait);
    ph_front();
    if (!(opc inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F})) begin
      trap_cycles(1'b0);
      return;
    end
    o = idle_o();
    o.dbus_sel = (opc == 7'h17 || opc == 7'h6F) ? 2'd0 : 2'd1;
    case (opc)
      7'h33, 7'h13, 7'h37, 7'h17: begin
        o.rf_we = rdnz; o.retire = 1'b1;
        cyc(1'b0, 1'b1, o, "EXEC");
      end
      7'h63: begin
        o.pc_ld = 1'b1; o.retire = 1'b1;
        cyc(1'b0, 1'b1, o, "EXEC");
      end
      7'h0F: begin
        o.retire = 1'b1;
        cyc(1'b0, 1'b1, o, "EXEC");
      end
      7'h6F, 7'h67: begin
        o.mar_ld = 1'b1; o.rf_we = rdnz; o.wb_sel = 2'd2;
        cyc(1'b0, 1'b1, o, "EXEC");
        o = idle_o();
        o.pc_ld = 1'b1; o.pc_src = 1'b1; o.retire = 1'b1;
        cyc(1'b0, 1'b1, o, "JUMP");
      end
      default: begin
        o.mar_ld = 1'b1;
        cyc(1'b0, 1'b1, o, "EXEC");
        o = idle_o();
        o.mem_req  = 1'b1;
        o.addr_sel = 1'b1;
        o.mem_size = instr[13:12];
        o.mem_we   = st;
        o.dbus_sel = st ? 2'd1 : 2'd3;
        if (mwait < 0) begin
          repeat (TMO) cyc(1'b0, 1'b0, o, "MEMW");
          trap_cycles(1'b1);
          return;
        end
        repeat (mwait) cyc(1'b0, 1'b0, o, "MEMW");
        o.retire = st;
        cyc(1'b0, 1'b1, o, "MEM");
        if (!st) begin
          o = idle_o();
          o.rf_we = rdnz; o.wb_sel = 2'd1; o.retire = 1'b1;
          cyc(1'b0, 1'b1, o, "WB");
        end
      end
    endcase
  endtask

  initial begin
    out_t o;
    do_reset();
    run_instr(32'h00500093, 0, 0);   // ADDI x1,x0,5
    run_instr(32'h00500093, 2, 0);   // same, fetch stalls two cycles
    run_instr(32'h0040A103, 0, 3);   // LW x2,4(x1), memory late by 3
    run_instr(32'h00208023, 0, 0);   // SB x2,0(x1)
    run_instr(32'h0080006F, 0, 0);   // JAL x0,8
    run_instr(32'h000100E7, 0, 0);   // JALR x1,0(x2)
    run_instr(32'h00208463, 0, 0);   // BEQ x1,x2,8
    run_instr(32'h00001197, 0, 0);   // AUIPC x3,1
    run_instr(32'h00001037, 0, 0);   // LUI x0,1
    run_instr(32'h0000000F, 0, 0);   // FENCE
    run_instr(32'h0000007F, 0, 0);   // illegal opcode
    do_reset();
    run_instr(32'h00500093, 0, 0);
    run_instr(32'h0040A103, 0, -1);  // load with no memory answer
    do_reset();
    // store aborted by reset in its first MEM cycle
    cur_ir = 32'h00208023;
    ph_fetch(0);
    ph_front();
    o = idle_o();
    o.dbus_sel = 2'd1;
    o.mar_ld   = 1'b1;
    cyc(1'b0, 1'b1, o, "EXEC");
    do_reset();
    run_instr(32'h00500093, 0, 0);
    cyc(1'b0, 1'b0, '{mem_req: 1'b1, mem_size: 2'd2, dbus_sel: 2'd3, default: 1'b0}, "FETCH");
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
